// File: rtl/updown_counter_mod.sv
// Parametrised up/down event counter with wrap/saturate bounds, parallel load,
// an enable prescaler, a terminal-count pulse and sticky overflow/underflow flags.
module updown_counter_mod #(
  parameter int WIDTH     = 4,
  parameter int MAX_COUNT = 9,
  parameter int PRESCALE  = 1
) (
  input  logic             CLOCK,
  input  logic             RESET,
  input  logic             ENABLE,
  input  logic             CONTROL,
  input  logic             SAT_MODE,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] LOAD_VALUE,
  input  logic             CLEAR_FLAGS,
  output logic [WIDTH-1:0] COUNT,
  output logic             TC,
  output logic             OVERFLOW,
  output logic             UNDERFLOW
);

  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [WIDTH-1:0] MAX_V   = WIDTH'(MAX_COUNT);
  localparam logic [PS_W-1:0]  PS_LAST = PS_W'(PRESCALE - 1);

  function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] v);
    return (v > MAX_V) ? MAX_V : v;
  endfunction

  logic [PS_W-1:0]  ps_p1;
  logic [WIDTH-1:0] count_p1;
  logic             tc_p1;
  logic             ovf_p1;
  logic             unf_p1;

  logic             step;
  logic             at_max;
  logic             at_zero;
  logic             hit_max;
  logic             hit_zero;
  logic [WIDTH-1:0] count_nxt;
  logic [PS_W-1:0]  ps_nxt;

  always_comb begin
    step      = ENABLE && (ps_p1 == PS_LAST);
    at_max    = (count_p1 == MAX_V);
    at_zero   = (count_p1 == '0);
    hit_max   = step && CONTROL && at_max;
    hit_zero  = step && !CONTROL && at_zero;
    count_nxt = count_p1;
    ps_nxt    = ps_p1;
    if (ENABLE) ps_nxt = step ? '0 : ps_p1 + PS_W'(1);
    if (step) begin
      // Boundary attempts either wrap to the opposite bound or hold in place.
      if (CONTROL) begin
        if (!at_max)       count_nxt = count_p1 + WIDTH'(1);
        else if (!SAT_MODE) count_nxt = '0;
      end else begin
        if (!at_zero)      count_nxt = count_p1 - WIDTH'(1);
        else if (!SAT_MODE) count_nxt = MAX_V;
      end
    end
  end

  // ---- stage p1: registered count, prescaler phase, TC and flags ----
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      count_p1 <= '0;
      ps_p1    <= '0;
      tc_p1    <= 1'b0;
      ovf_p1   <= 1'b0;
      unf_p1   <= 1'b0;
    end else if (LOAD) begin
      count_p1 <= clamp_load(LOAD_VALUE);
      ps_p1    <= '0;
      tc_p1    <= 1'b0;
      if (CLEAR_FLAGS) begin
        ovf_p1 <= 1'b0;
        unf_p1 <= 1'b0;
      end
    end else begin
      count_p1 <= count_nxt;
      ps_p1    <= ps_nxt;
      tc_p1    <= hit_max || hit_zero;
      // A boundary event in the clearing cycle keeps its flag set.
      ovf_p1   <= hit_max  || (ovf_p1 && !CLEAR_FLAGS);
      unf_p1   <= hit_zero || (unf_p1 && !CLEAR_FLAGS);
    end
  end

  assign COUNT     = count_p1;
  assign TC        = tc_p1;
  assign OVERFLOW  = ovf_p1;
  assign UNDERFLOW = unf_p1;

endmodule

// File: tb/tb_updown_counter_mod.sv
// Directed bench for updown_counter_mod: one instance at PRESCALE=1, one at PRESCALE=3.
module tb_updown_counter_mod;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, en, ctl, sat, ld, clr;
  logic [3:0] ldv;
  logic [3:0] count;
  logic       tc, ovf, unf;

  logic       rst3, en3, ctl3, sat3, ld3, clr3;
  logic [3:0] ldv3;
  logic [3:0] count3;
  logic       tc3, ovf3, unf3;

  int n_tests = 0;
  int n_fail  = 0;

  updown_counter_mod #(.WIDTH(4), .MAX_COUNT(9), .PRESCALE(1)) dut (
    .CLOCK(clk), .RESET(rst), .ENABLE(en), .CONTROL(ctl), .SAT_MODE(sat),
    .LOAD(ld), .LOAD_VALUE(ldv), .CLEAR_FLAGS(clr),
    .COUNT(count), .TC(tc), .OVERFLOW(ovf), .UNDERFLOW(unf)
  );

  updown_counter_mod #(.WIDTH(4), .MAX_COUNT(9), .PRESCALE(3)) dut3 (
    .CLOCK(clk), .RESET(rst3), .ENABLE(en3), .CONTROL(ctl3), .SAT_MODE(sat3),
    .LOAD(ld3), .LOAD_VALUE(ldv3), .CLEAR_FLAGS(clr3),
    .COUNT(count3), .TC(tc3), .OVERFLOW(ovf3), .UNDERFLOW(unf3)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int up_seq[12]  = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
  int dn_seq[4]   = '{1, 0, 9, 8};
  int dn_tc[4]    = '{0, 0, 1, 0};
  int sat_tc[4]   = '{0, 1, 1, 1};
  int ps_seq[6]   = '{0, 0, 1, 1, 1, 2};

  initial begin
    rst = 1'b1; en = 1'b1; ctl = 1'b1; sat = 1'b0; ld = 1'b0; clr = 1'b0; ldv = 4'd0;
    rst3 = 1'b1; en3 = 1'b0; ctl3 = 1'b1; sat3 = 1'b0; ld3 = 1'b0; clr3 = 1'b0; ldv3 = 4'd0;

    // 1: reset with ENABLE high, then count up through the wrap
    tick(); tick();
    chk("rst_count", count, 0);
    chk("rst_tc", tc, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_unf", unf, 0);
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      chk($sformatf("up_count[%0d]", i), count, up_seq[i]);
      chk($sformatf("up_tc[%0d]", i), tc, (i == 9) ? 1 : 0);
    end
    chk("up_ovf", ovf, 1);
    chk("up_unf", unf, 0);

    // 2: load 2, count down through the wrap
    ld = 1'b1; ldv = 4'd2;
    tick();
    chk("ld2_count", count, 2);
    chk("ld2_tc", tc, 0);
    ld = 1'b0; ctl = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("dn_count[%0d]", i), count, dn_seq[i]);
      chk($sformatf("dn_tc[%0d]", i), tc, dn_tc[i]);
    end
    chk("dn_unf", unf, 1);
    chk("dn_ovf", ovf, 1);

    // 3: saturate at the top
    sat = 1'b1; ld = 1'b1; ldv = 4'd8;
    tick();
    chk("ld8_count", count, 8);
    ld = 1'b0; ctl = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("sat_count[%0d]", i), count, 9);
      chk($sformatf("sat_tc[%0d]", i), tc, sat_tc[i]);
    end
    chk("sat_ovf", ovf, 1);
    ctl = 1'b0;
    tick();
    chk("sat_down_count", count, 8);
    chk("sat_down_tc", tc, 0);

    // 4: clamped load, flag clearing, set beats clear
    ld = 1'b1; ldv = 4'd15; en = 1'b1; ctl = 1'b1; sat = 1'b0;
    tick();
    chk("ld15_count", count, 9);
    chk("ld15_tc", tc, 0);
    ld = 1'b0; en = 1'b0; clr = 1'b1;
    tick();
    chk("clr_ovf", ovf, 0);
    chk("clr_unf", unf, 0);
    chk("clr_count", count, 9);
    en = 1'b1;
    tick();
    chk("clrset_count", count, 0);
    chk("clrset_tc", tc, 1);
    chk("clrset_ovf", ovf, 1);
    chk("clrset_unf", unf, 0);
    en = 1'b0;
    tick();
    chk("clr2_ovf", ovf, 0);
    chk("clr2_tc", tc, 0);
    clr = 1'b0;

    // 5: prescaler of 3, with an enable gap
    tick();
    chk("p3_rst_count", count3, 0);
    rst3 = 1'b0; en3 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk($sformatf("p3_count[%0d]", i), count3, ps_seq[i]);
    end
    tick(); tick();
    chk("p3_pre_gap", count3, 2);
    en3 = 1'b0;
    tick(); tick();
    chk("p3_gap", count3, 2);
    en3 = 1'b1;
    tick();
    chk("p3_resume", count3, 3);
    chk("p3_tc", tc3, 0);

    // 6: reset overrides load mid-count and clears the prescaler phase
    for (int i = 0; i < 6; i++) tick();
    chk("p3_at5", count3, 5);
    tick();
    rst3 = 1'b1; ld3 = 1'b1; ldv3 = 4'd7;
    tick();
    chk("p3_rst_ovr_count", count3, 0);
    chk("p3_rst_ovr_tc", tc3, 0);
    chk("p3_rst_ovr_ovf", ovf3, 0);
    chk("p3_rst_ovr_unf", unf3, 0);
    rst3 = 1'b0; ld3 = 1'b0;
    tick();
    chk("p3_post_rst0", count3, 0);
    tick();
    chk("p3_post_rst1", count3, 0);
    tick();
    chk("p3_post_rst2", count3, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
